// File: rtl/blade_ignition_ctrl.sv
// Blade ignition/retraction controller: length ramp FSM and emitter colour drive.
// Optional `BLADE_FLICKER_EN adds an LFSR-driven flicker while the blade is lit.
module blade_ignition_ctrl #(
  parameter int unsigned STEP       = 8,
  parameter int unsigned WARN_SHIFT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       on,
  input  logic [1:0] len_in,
  input  logic [5:0] len_dec,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  input  logic [7:0] power_level,
  input  logic       power_warn,
  output logic [8:0] blade_len,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic [1:0] state,
  output logic       lit
);

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    IGNITE  = 2'd1,
    LIT     = 2'd2,
    RETRACT = 2'd3
  } st_t;

  st_t        st;
  logic [8:0] tgt;
  logic       go;
  logic [9:0] up;
  logic [9:0] dn_lim;
  logic [8:0] toward;
  logic [8:0] shrunk;
  logic [8:0] nlen;
  logic [7:0] lfsr;
  logic       flick;

  assign tgt    = 9'(len_in) * 9'd100 + 9'(len_dec);
  assign go     = on && (power_level != 8'd0) && (tgt != 9'd0);
  assign up     = {1'b0, blade_len} + 10'(STEP);
  assign dn_lim = {1'b0, tgt} + 10'(STEP);

  // Step toward the live target, landing exactly on it.
  always_comb begin
    toward = tgt;
    if (blade_len < tgt) begin
      if (up < {1'b0, tgt}) toward = up[8:0];
    end else if ({1'b0, blade_len} > dn_lim) begin
      toward = blade_len - 9'(STEP);
    end
  end

  assign shrunk = (blade_len >= 9'(STEP)) ? blade_len - 9'(STEP) : 9'd0;

  always_comb begin
    nlen = blade_len;
    unique case (st)
      OFF:         nlen = 9'd0;
      IGNITE, LIT: nlen = go ? toward : blade_len;
      RETRACT:     nlen = go ? blade_len : shrunk;
      default:     nlen = 9'd0;
    endcase
  end

`ifdef BLADE_FLICKER_EN
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else if (st == LIT)
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign flick = lfsr[0];
`else
  assign lfsr  = 8'h00;
  assign flick = 1'b0;
`endif

  function automatic logic [7:0] paint(
    input logic [8:0] len,
    input logic [7:0] c,
    input logic       warn,
    input logic       fl
  );
    logic [7:0] v;
    v = warn ? (c >> WARN_SHIFT) : c;
    if (fl) v = v - (v >> 3);
    return (len == 9'd0) ? 8'd0 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= OFF;
      blade_len <= 9'd0;
      r_out     <= 8'd0;
      g_out     <= 8'd0;
      b_out     <= 8'd0;
    end else begin
      blade_len <= nlen;
      r_out     <= paint(nlen, r_in, power_warn, flick);
      g_out     <= paint(nlen, g_in, power_warn, flick);
      b_out     <= paint(nlen, b_in, power_warn, flick);
      unique case (st)
        OFF:     if (go) st <= IGNITE;
        IGNITE: begin
          if (!go) st <= RETRACT;
          else if (nlen == tgt) st <= LIT;
        end
        LIT:     if (!go) st <= RETRACT;
        RETRACT: begin
          if (go) st <= IGNITE;
          else if (nlen == 9'd0) st <= OFF;
        end
        default: st <= OFF;
      endcase
    end
  end

  assign state = st;
  assign lit   = (st == LIT);

  logic unused;
  assign unused = ^lfsr[7:1];

endmodule

// File: tb/tb_blade_ignition_ctrl.sv
// Bench for blade_ignition_ctrl: cycle model of the length/colour rules
// plus directed scenarios with literal expectations.
module tb_blade_ignition_ctrl;
  localparam int STEP = 8;
  localparam int WS   = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       on = 1'b0;
  logic [1:0] len_in = 2'd0;
  logic [5:0] len_dec = 6'd0;
  logic [7:0] r_in = 8'd0, g_in = 8'd0, b_in = 8'd0;
  logic [7:0] power_level = 8'd0;
  logic       power_warn = 1'b0;
  logic [8:0] blade_len;
  logic [7:0] r_out, g_out, b_out;
  logic [1:0] state;
  logic       lit;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  blade_ignition_ctrl #(.STEP(STEP), .WARN_SHIFT(WS)) dut (
    .clk(clk), .rst(rst), .on(on),
    .len_in(len_in), .len_dec(len_dec),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .power_level(power_level), .power_warn(power_warn),
    .blade_len(blade_len),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .state(state), .lit(lit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int len;
    int r, g, b;
    int lf;
  } mdl_t;

  mdl_t m = '{0, 0, 0, 0, 0, 8'hA5};

  function automatic int shade(int c, int len, bit flk);
    int v;
    v = power_warn ? (c >> WS) : c;
    if (flk) v = v - (v >> 3);
    return (len == 0) ? 0 : v;
  endfunction

  // Next model state from the current inputs, written from the length rules.
  function automatic mdl_t next(mdl_t c);
    mdl_t n;
    int t;
    bit go;
    bit flk;
    n = c;
    t = int'(len_in) * 100 + int'(len_dec);
    go = on && (power_level != 0) && (t != 0);
    flk = 1'b0;
`ifdef BLADE_FLICKER_EN
    flk = c.lf[0];
    if (c.st == 2)
      n.lf = ((c.lf << 1) & 8'hFE) |
             (((c.lf >> 7) ^ (c.lf >> 5) ^ (c.lf >> 4) ^ (c.lf >> 3)) & 1);
`endif
    if (rst) begin
      n = '{0, 0, 0, 0, 0, 8'hA5};
      return n;
    end
    case (c.st)
      0: begin
        n.len = 0;
        n.st = go ? 1 : 0;
      end
      1, 2: begin
        if (!go) begin
          n.st = 3;
        end else begin
          if (c.len < t) n.len = (c.len + STEP > t) ? t : c.len + STEP;
          else n.len = (c.len - STEP < t) ? t : c.len - STEP;
          n.st = (c.st == 2 || n.len == t) ? 2 : 1;
        end
      end
      default: begin
        if (go) begin
          n.st = 1;
        end else begin
          n.len = (c.len - STEP < 0) ? 0 : c.len - STEP;
          n.st = (n.len == 0) ? 0 : 3;
        end
      end
    endcase
    n.r = shade(int'(r_in), n.len, flk);
    n.g = shade(int'(g_in), n.len, flk);
    n.b = shade(int'(b_in), n.len, flk);
    return n;
  endfunction

  always @(posedge clk) begin
    m <= next(m);
    if (rst) armed <= 1'b1;
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("m.state", int'(state), m.st);
      check("m.len", int'(blade_len), m.len);
      check("m.lit", int'(lit), int'(m.st == 2));
      check("m.r", int'(r_out), m.r);
      check("m.g", int'(g_out), m.g);
      check("m.b", int'(b_out), m.b);
      if (int'(blade_len) > 363) check("len.max", int'(blade_len), 363);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rgb(input string nm, input int r, input int g, input int b);
    check({nm, ".r"}, int'(r_out), r);
    check({nm, ".g"}, int'(g_out), g);
    check({nm, ".b"}, int'(b_out), b);
  endtask

  initial begin
    tick(2);
    check("rst.state", int'(state), 0);
    check("rst.len", int'(blade_len), 0);
    check("rst.lit", int'(lit), 0);
    rgb("rst", 0, 0, 0);

    on = 1; len_in = 1; len_dec = 50; power_level = 200;
    r_in = 255; g_in = 47; b_in = 3;
    rst = 0;
    tick(1);
    check("ign.state", int'(state), 1);
    check("ign.len0", int'(blade_len), 0);
    tick(18);
    check("ign.len144", int'(blade_len), 144);
    check("ign.still", int'(state), 1);
    tick(1);
    check("lit.state", int'(state), 2);
    check("lit.len", int'(blade_len), 150);
    check("lit.lit", int'(lit), 1);
    rgb("lit", 255, 47, 3);

    power_warn = 1;
    tick(1);
    rgb("warn", 127, 23, 1);
    power_warn = 0;
    tick(1);
    rgb("nowarn", 255, 47, 3);

    on = 0;
    tick(1);
    check("ret.state", int'(state), 3);
    check("ret.len", int'(blade_len), 150);
    tick(10);
    check("ret.len70", int'(blade_len), 70);
    on = 1;
    tick(1);
    check("reign.state", int'(state), 1);
    check("reign.len", int'(blade_len), 70);
    tick(1);
    check("reign.len78", int'(blade_len), 78);
    tick(9);
    check("reign.lit", int'(state), 2);
    check("reign.len150", int'(blade_len), 150);

    len_in = 2; len_dec = 33;
    tick(10);
    check("grow.len230", int'(blade_len), 230);
    tick(1);
    check("grow.len233", int'(blade_len), 233);
    check("grow.state", int'(state), 2);
    power_level = 0;
    tick(1);
    check("pwr.state", int'(state), 3);
    check("pwr.len", int'(blade_len), 233);
    tick(29);
    check("pwr.len1", int'(blade_len), 1);
    tick(1);
    check("off.state", int'(state), 0);
    check("off.len", int'(blade_len), 0);
    rgb("off", 0, 0, 0);

    len_in = 0; len_dec = 0; power_level = 200;
    tick(3);
    check("tgt0.state", int'(state), 0);

    len_in = 1; len_dec = 50;
    tick(6);
    check("rst40.len", int'(blade_len), 40);
    rst = 1;
    tick(1);
    check("rst40.state", int'(state), 0);
    check("rst40.len0", int'(blade_len), 0);
    rgb("rst40", 0, 0, 0);
    rst = 0;
    tick(1);
    check("rel.state", int'(state), 1);

    tick(12);
    check("red.len96", int'(blade_len), 96);
    len_in = 0; len_dec = 50;
    tick(1);
    check("red.len88", int'(blade_len), 88);
    check("red.ign", int'(state), 1);
    tick(5);
    check("red.len50", int'(blade_len), 50);
    check("red.lit", int'(state), 2);

    len_in = 3; len_dec = 63;
    tick(40);
    check("max.len", int'(blade_len), 363);
    check("max.state", int'(state), 2);
    on = 0;
    tick(50);
    check("end.state", int'(state), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/blade_ignition_ctrl.md
BLADE_IGNITION_CTRL -- requirements
Module: blade_ignition_ctrl

Interface
REQ-001 SHALL have parameter STEP, default 8, blade growth/shrink per clock in hundredths of a metre (1..63).
REQ-002 SHALL have parameter WARN_SHIFT, default 1, right-shift applied to colour while power warning is active (0..7).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port on  input  1  saber on request (from on/off register).
REQ-006 SHALL have port len_in  input  2  target length, whole metres.
REQ-007 SHALL have port len_dec  input  6  target length, hundredths (0..63).
REQ-008 SHALL have port r_in, g_in, b_in  input  8 each  colour register outputs.
REQ-009 SHALL have port power_level  input  8  remaining power (from power block).
REQ-010 SHALL have port power_warn  input  1  low-power warning.
REQ-011 SHALL have port blade_len  output  9  current extended length, hundredths.
REQ-012 SHALL have port r_out, g_out, b_out  output  8 each  blade emitter drive.
REQ-013 SHALL have port state  output  2  OFF=0, IGNITE=1, LIT=2, RETRACT=3.
REQ-014 SHALL have port lit  output  1  high iff state==LIT.

Function
REQ-015 target SHALL be len_in*100+len_dec, 9 bits unsigned (max 363), evaluated live each cycle.
REQ-016 pwr_ok SHALL mean power_level!=0.
REQ-017 OFF: blade_len held 0; on && pwr_ok && target!=0 -> IGNITE next edge, blade_len unchanged.
REQ-018 IGNITE: blade_len <= min(blade_len+STEP, target); when updated value equals target -> LIT on the same edge.
REQ-019 IGNITE with blade_len > target (target reduced mid-ignition): blade_len <= max(blade_len-STEP, target); LIT when equal.
REQ-020 LIT: blade_len steps toward target by at most STEP per cycle, saturating exactly at target.
REQ-021 IGNITE or LIT: !on, !pwr_ok, or target==0 -> RETRACT next edge, blade_len unchanged on that edge.
REQ-022 RETRACT: blade_len <= max(blade_len-STEP, 0); updated value 0 -> OFF same edge.
REQ-023 RETRACT: on && pwr_ok && target!=0 has priority over shrinking -> IGNITE next edge, blade_len unchanged (re-extend from current length).
REQ-024 Colour outputs SHALL be registered, one-cycle latency: 0 when next blade_len==0, else {r,g,b}_in >> (power_warn ? WARN_SHIFT : 0).
REQ-025 blade_len SHALL never exceed 363 nor underflow below 0.

Reset
REQ-026 rst high on a rising edge SHALL force state=OFF, blade_len=0, r_out=g_out=b_out=0, lit=0, overriding all other inputs, including mid-ignition or mid-retraction.
REQ-027 The first edge after rst deasserts SHALL evaluate REQ-017 normally.

Configuration
REQ-028 Macro BLADE_FLICKER_EN, when defined, SHALL add an 8-bit LFSR (x^8+x^6+x^5+x^4+1, reset seed 8'hA5) advancing each LIT cycle; when LFSR bit0=1, each colour output is reduced by (its post-REQ-024 value >> 3).
REQ-029 Without BLADE_FLICKER_EN, no LFSR SHALL exist and colour follows REQ-024 exactly.

Verification
REQ-030 rst, then on=1, len 1.50, power 200, RGB 255/47/3 -> IGNITE after 1 edge, blade_len +8 per edge, LIT with blade_len=150 on edge 20, RGB out 255/47/3.
REQ-031 LIT at 150, power_warn=1 -> next edge RGB out 127/23/1; power_warn=0 -> 255/47/3.
REQ-032 LIT at 150, on=0 -> RETRACT, blade_len 142,134,... reaching 0 and OFF after 19 shrink edges; RGB out 0 when length 0.
REQ-033 RETRACT at blade_len 70, on=1 -> IGNITE next edge, grows 70->78->... back to 150, LIT.
REQ-034 LIT at 150, target changed to 2.33 -> blade_len steps +8 to 233 (last step +3), state stays LIT; power_level=0 -> RETRACT.
REQ-035 IGNITE at blade_len 40, rst=1 -> next edge state OFF, blade_len 0, RGB 0; with BLADE_FLICKER_EN, LFSR=8'hA5.
